// File: rtl/dmem_line_responder.sv
// Line-granular memory responder for the dcache miss port.
// One request in flight, fixed latency, single-cycle ack.
module dmem_line_responder #(
  parameter int LATENCY    = 10,
  parameter int LINE_W     = 256,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  logic [LINE_W-1:0] memory [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  wr_q, wr_d;
  logic [LINE_W-1:0]     data_q, data_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;

  logic                  do_commit;
  logic                  c_wr;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [LINE_W-1:0]     c_line;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] addr_idx;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

  assign addr_idx = addr_i[DEPTH_LOG2+4:5];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    line_d    = line_q;
    wr_d      = wr_q;
    data_d    = data_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    do_commit = 1'b0;
    c_wr      = wr_q;
    c_idx     = idx_q;
    c_line    = line_q;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d  = addr_idx;
          line_d = data_i;
          wr_d   = write_i;
          cnt_d  = 8'd1;
          if (LATENCY == 1) begin
            // single-cycle build commits straight from the inputs
            state_d   = ACK;
            do_commit = 1'b1;
            c_wr      = write_i;
            c_idx     = addr_idx;
            c_line    = data_i;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT_M1) begin
          state_d   = ACK;
          do_commit = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (do_commit) begin
      if (c_wr) begin
        mem_we   = 1'b1;
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        data_d   = memory[c_idx];
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      line_q   <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // storage is never reset; a held reset must not let a commit through
  always_ff @(posedge clk_i) begin
    if (mem_we && rst_i) begin
      memory[c_idx] <= c_line;
    end
  end

  assign ack_o    = (state_q == ACK);
  assign busy_o   = (state_q != IDLE);
  assign data_o   = data_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Scoreboard bench for dmem_line_responder.
// Two instances: LATENCY=10 and LATENCY=1.
module tb_dmem_line_responder;

  localparam int L0 = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         en = 1'b0;
  logic         wr = 1'b0;
  logic         ack0, busy0;
  logic [255:0] rdata0;
  logic [31:0]  rdc0, wrc0;

  logic [31:0]  addr1 = '0;
  logic [255:0] wdata1 = '0;
  logic         en1 = 1'b0;
  logic         wr1 = 1'b0;
  logic         ack1, busy1;
  logic [255:0] rdata1;
  logic [31:0]  rdc1, wrc1;

  dmem_line_responder #(.LATENCY(L0)) dut (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
    .enable_i(en), .write_i(wr), .ack_o(ack0), .data_o(rdata0),
    .busy_o(busy0), .rd_cnt_o(rdc0), .wr_cnt_o(wrc0)
  );

  dmem_line_responder #(.LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr1), .data_i(wdata1),
    .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(rdata1),
    .busy_o(busy1), .rd_cnt_o(rdc1), .wr_cnt_o(wrc1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         rd;
    logic [255:0] data;
    int           acyc;
    logic [31:0]  rdc;
    logic [31:0]  wrc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] model [512];
  logic [31:0]  mrd = '0;
  logic [31:0]  mwr = '0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack0_spurious: got ack at cyc %0d want none", cyc);
      end else begin
        e = q0.pop_front();
        chk("ack0_cycle", 256'(cyc), 256'(e.acyc));
        if (e.rd) chk("rd0_data", rdata0, e.data);
        chk("rd0_cnt", 256'(rdc0), 256'(e.rdc));
        chk("wr0_cnt", 256'(wrc0), 256'(e.wrc));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack1_spurious: got ack at cyc %0d want none", cyc);
      end else begin
        e = q1.pop_front();
        chk("ack1_cycle", 256'(cyc), 256'(e.acyc));
        if (e.rd) chk("rd1_data", rdata1, e.data);
        chk("rd1_cnt", 256'(rdc1), 256'(e.rdc));
        chk("wr1_cnt", 256'(wrc1), 256'(e.wrc));
      end
    end
  end

  function automatic exp_t mk(input logic w, input logic [31:0] a,
                              input logic [255:0] d);
    exp_t e;
    int idx;
    idx = int'(a[13:5]);
    if (w) begin
      model[idx] = d;
      mwr = mwr + 32'd1;
    end else begin
      mrd = mrd + 32'd1;
    end
    e.rd   = !w;
    e.data = model[idx];
    e.acyc = cyc + L0;
    e.rdc  = mrd;
    e.wrc  = mwr;
    return e;
  endfunction

  task automatic wait_ack(input bit scr, output int nb);
    bit seen;
    seen = 1'b0;
    nb = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (busy0) nb++;
      if (ack0) begin
        seen = 1'b1;
        if (scr) en = 1'b0;
      end else if (scr) begin
        addr  = $urandom;
        wdata = {8{$urandom}};
        wr    = 1'($urandom);
        en    = 1'($urandom);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack0_timeout: got no ack want ack");
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a,
                     input logic [255:0] d, input bit scr);
    int nb;
    @(posedge clk); #1;
    en = 1'b1; wr = w; addr = a; wdata = d;
    q0.push_back(mk(w, a, d));
    @(posedge clk); #1;
    if (!scr) en = 1'b0;
    wait_ack(scr, nb);
    chk("busy_cycles", 256'(nb), 256'(L0));
    @(posedge clk);
  endtask

  task automatic check_mem();
    for (int i = 0; i < 8; i++)
      chk($sformatf("mem[%0d]", i), dut.memory[i], model[i]);
    chk("mem[32]", dut.memory[32], model[32]);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nb;
    int c;
    exp_t e;
    logic [255:0] d3, d4, d6;
    d3 = {8{32'h0BAD_F00D}};
    d4 = {8{32'h4444_AAAA}};
    d6 = {8{32'h6666_1234}};
    for (int i = 0; i < 8; i++) begin
      model[i] = (256'(i) << 128) | 256'h5;
      dut.memory[i] = model[i];
    end
    model[32] = 256'hBAD;
    dut.memory[32] = model[32];
    u1.memory[0] = 256'h77;
    u1.memory[1] = 256'h88;

    repeat (2) @(negedge clk);
    chk("rst_ack", 256'(ack0), 256'(0));
    chk("rst_busy", 256'(busy0), 256'(0));
    chk("rst_data", rdata0, 256'(0));
    chk("rst_rdc", 256'(rdc0), 256'(0));
    chk("rst_wrc", 256'(wrc0), 256'(0));
    rst_n = 1'b1;

    // basic read of preloaded line 0
    req(1'b0, 32'h0000_0000, '0, 1'b0);
    // write then read with offset bits set
    req(1'b1, 32'h0000_0400, {8{32'hDEAD_BEEF}}, 1'b0);
    req(1'b0, 32'h0000_041F, '0, 1'b0);

    // write-back then allocate, enable held throughout
    @(posedge clk); #1;
    en = 1'b1; wr = 1'b1; addr = 32'h20; wdata = d3;
    q0.push_back(mk(1'b1, 32'h20, d3));
    wait_ack(1'b0, nb);
    @(posedge clk); #1;
    wr = 1'b0; addr = 32'h40;
    q0.push_back(mk(1'b0, 32'h40, '0));
    wait_ack(1'b0, nb);
    @(posedge clk); #1;
    en = 1'b0;
    chk("wb_mem1", dut.memory[1], model[1]);
    chk("alloc_data", rdata0, model[2]);

    // inputs scrambled while busy
    req(1'b1, 32'h0000_0060, d4, 1'b1);
    check_mem();

    // reset in the middle of a write
    @(posedge clk); #1;
    en = 1'b1; wr = 1'b1; addr = 32'h80; wdata = {8{32'h1234_5678}};
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 256'(ack0), 256'(0));
    chk("mid_rst_busy", 256'(busy0), 256'(0));
    chk("mid_rst_rdc", 256'(rdc0), 256'(0));
    chk("mid_rst_wrc", 256'(wrc0), 256'(0));
    mrd = '0;
    mwr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("mid_rst_mem4", dut.memory[4], model[4]);
    req(1'b0, 32'h0000_0080, '0, 1'b0);

    // single-cycle build: write then held reads, ack every 2 cycles
    @(posedge clk); #1;
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h20; wdata1 = d6;
    c = cyc;
    e.rd = 1'b0; e.data = d6; e.acyc = c + 1; e.rdc = 0; e.wrc = 1;
    q1.push_back(e);
    for (int k = 1; k <= 3; k++) begin
      e.rd = 1'b1; e.data = d6; e.acyc = c + 1 + 2 * k;
      e.rdc = 32'(k); e.wrc = 1;
      q1.push_back(e);
    end
    @(posedge clk); #1;
    wr1 = 1'b0;
    repeat (7) @(posedge clk);
    #1 en1 = 1'b0;
    chk("u1_mem1", u1.memory[1], d6);

    repeat (4) @(posedge clk);
    chk("q0_empty", 256'(q0.size()), 256'(0));
    chk("q1_empty", 256'(q1.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
